// File: rtl/ga_sequencer.sv
// Sequences the init, selection, mutation and report stages of a generation loop and owns the population register.
// Each stage start pulse is registered and appears one cycle after the done pulse that triggers it; stages stall the loop simply by withholding done.
module ga_sequencer #(
  parameter int IND_BITS  = 150,
  parameter int POP_SIZE  = 50,
  parameter int POP_BITS  = IND_BITS * POP_SIZE,
  parameter int GEN_W     = 16,
  parameter int RPT_EVERY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                step_mode,
  input  logic                abort,
  input  logic [GEN_W-1:0]    max_gen,
  input  logic [POP_BITS-1:0] init_pop,
  input  logic [POP_BITS-1:0] mut_pop,
  input  logic                init_done,
  input  logic                sel_done,
  input  logic                mut_done,
  input  logic                rpt_done,
  output logic [POP_BITS-1:0] population,
  output logic                init_start,
  output logic                sel_start,
  output logic                mut_start,
  output logic                rpt_start,
  output logic [GEN_W-1:0]    gen_count,
  output logic [2:0]          state_out,
  output logic                busy,
  output logic                finished
);

  localparam int RC_W = (RPT_EVERY > 1) ? $clog2(RPT_EVERY) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_SEL  = 3'd2,
    S_MUT  = 3'd3,
    S_RPT  = 3'd4,
    S_HOLD = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [POP_BITS-1:0] pop_q, pop_d;
  logic [GEN_W-1:0]    gen_q, gen_d;
  logic [GEN_W-1:0]    lim_q, lim_d;
  logic [RC_W-1:0]     rc_q, rc_d;
  logic                init_start_q, init_start_d;
  logic                sel_start_q, sel_start_d;
  logic                mut_start_q, mut_start_d;
  logic                rpt_start_q, rpt_start_d;

  // Decision taken once a generation (and its optional report) is complete.
  function automatic state_t post_gen(input logic [GEN_W-1:0] gen,
                                      input logic [GEN_W-1:0] lim,
                                      input logic             step);
    if (lim != '0 && gen == lim) return S_DONE;
    else if (step)               return S_HOLD;
    else                         return S_SEL;
  endfunction

  always_comb begin
    state_d = state_q;
    pop_d   = pop_q;
    gen_d   = gen_q;
    lim_d   = lim_q;
    rc_d    = rc_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE && abort) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_INIT;
          lim_d   = max_gen;
          gen_d   = '0;
          rc_d    = '0;
        end
      end
      S_INIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (init_done) begin
          pop_d   = init_pop;
          state_d = (lim_q != '0 && gen_q == lim_q) ? S_DONE : S_SEL;
        end
      end
      S_SEL: begin
        if (abort)         state_d = S_IDLE;
        else if (sel_done) state_d = S_MUT;
      end
      S_MUT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (mut_done) begin
          pop_d = mut_pop;
          gen_d = gen_q + GEN_W'(1);
          if (rc_q == RC_W'(RPT_EVERY - 1)) begin
            rc_d    = '0;
            state_d = S_RPT;
          end else begin
            rc_d    = rc_q + RC_W'(1);
            state_d = post_gen(gen_d, lim_q, step_mode);
          end
        end
      end
      S_RPT: begin
        if (abort)         state_d = S_IDLE;
        else if (rpt_done) state_d = post_gen(gen_q, lim_q, step_mode);
      end
      S_HOLD: begin
        if (abort)      state_d = S_IDLE;
        else if (start) state_d = S_SEL;
      end
      default: state_d = S_IDLE;
    endcase

    // A stage is never re-entered from itself, so entry equals a state change into it.
    init_start_d = (state_d == S_INIT) && (state_q != S_INIT);
    sel_start_d  = (state_d == S_SEL)  && (state_q != S_SEL);
    mut_start_d  = (state_d == S_MUT)  && (state_q != S_MUT);
    rpt_start_d  = (state_d == S_RPT)  && (state_q != S_RPT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pop_q        <= '0;
      gen_q        <= '0;
      lim_q        <= '0;
      rc_q         <= '0;
      init_start_q <= 1'b0;
      sel_start_q  <= 1'b0;
      mut_start_q  <= 1'b0;
      rpt_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pop_q        <= pop_d;
      gen_q        <= gen_d;
      lim_q        <= lim_d;
      rc_q         <= rc_d;
      init_start_q <= init_start_d;
      sel_start_q  <= sel_start_d;
      mut_start_q  <= mut_start_d;
      rpt_start_q  <= rpt_start_d;
    end
  end

  assign population = pop_q;
  assign gen_count  = gen_q;
  assign state_out  = state_q;
  assign init_start = init_start_q;
  assign sel_start  = sel_start_q;
  assign mut_start  = mut_start_q;
  assign rpt_start  = rpt_start_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_HOLD) && (state_q != S_DONE);
  assign finished   = (state_q == S_DONE);

endmodule

// File: tb/tb_ga_sequencer.sv
// Directed bench for ga_sequencer: instance a (GEN_W=4, report every generation), instance b (report every 3rd).
// Both instances share inputs; stage responses follow whichever instance is under test.
module tb_ga_sequencer;

  localparam int PB = 32;

  logic          clk = 1'b0;
  logic          rst, start, step_mode, abort;
  logic [15:0]   max_gen;
  logic [PB-1:0] init_pop, mut_pop;
  logic          init_done, sel_done, mut_done, rpt_done;

  logic [PB-1:0] a_pop, b_pop;
  logic          a_is, a_ss, a_ms, a_rs, a_busy, a_fin;
  logic          b_is, b_ss, b_ms, b_rs, b_busy, b_fin;
  logic [3:0]    a_gen;
  logic [15:0]   b_gen;
  logic [2:0]    a_state, b_state;

  logic          sel_b = 1'b0;
  int            checks = 0;
  int            errors = 0;
  int            dbl = 0;
  int            b_rpt_n = 0;
  logic [3:0]    a_prev = 4'b0;

  always #5 clk = ~clk;

  ga_sequencer #(.IND_BITS(8), .POP_SIZE(4), .GEN_W(4), .RPT_EVERY(1)) u_a (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .abort(abort),
    .max_gen(max_gen[3:0]), .init_pop(init_pop), .mut_pop(mut_pop),
    .init_done(init_done), .sel_done(sel_done), .mut_done(mut_done), .rpt_done(rpt_done),
    .population(a_pop), .init_start(a_is), .sel_start(a_ss), .mut_start(a_ms),
    .rpt_start(a_rs), .gen_count(a_gen), .state_out(a_state), .busy(a_busy), .finished(a_fin)
  );

  ga_sequencer #(.IND_BITS(8), .POP_SIZE(4), .GEN_W(16), .RPT_EVERY(3)) u_b (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .abort(abort),
    .max_gen(max_gen), .init_pop(init_pop), .mut_pop(mut_pop),
    .init_done(init_done), .sel_done(sel_done), .mut_done(mut_done), .rpt_done(rpt_done),
    .population(b_pop), .init_start(b_is), .sel_start(b_ss), .mut_start(b_ms),
    .rpt_start(b_rs), .gen_count(b_gen), .state_out(b_state), .busy(b_busy), .finished(b_fin)
  );

  // Background monitors: back-to-back start pulses on a, report pulses on b.
  always @(negedge clk) begin
    if (({a_is, a_ss, a_ms, a_rs} & a_prev) != 4'b0) dbl <= dbl + 1;
    a_prev  <= {a_is, a_ss, a_ms, a_rs};
    b_rpt_n <= b_rpt_n + int'(b_rs);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] cur_st();
    return sel_b ? {b_is, b_ss, b_ms, b_rs} : {a_is, a_ss, a_ms, a_rs};
  endfunction

  task automatic wait_start(output logic [3:0] s, output int w);
    s = 4'b0;
    w = 0;
    for (int i = 0; i < 20; i++) begin
      s = cur_st();
      if (s != 4'b0) break;
      w++;
      @(negedge clk);
    end
  endtask

  // Wait for a stage start, check which one, answer with its done pulse a few cycles later.
  task automatic stage(input logic [3:0] exp, input string tag, input bit lat0);
    logic [3:0] s;
    int         w;
    wait_start(s, w);
    chk(tag, s, exp);
    if (lat0) chk({tag, "_lat"}, w, 0);
    @(negedge clk);
    @(negedge clk);
    {init_done, sel_done, mut_done, rpt_done} = (s != 4'b0) ? s : exp;
    @(negedge clk);
    {init_done, sel_done, mut_done, rpt_done} = 4'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; step_mode = 1'b0;
    {init_done, sel_done, mut_done, rpt_done} = 4'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0]    s;
    int            w;
    int            rb0;
    logic [3:0]    acc;
    logic [PB-1:0] last_pop;
    max_gen  = '0;
    init_pop = '0;
    mut_pop  = '0;
    @(negedge clk);

    // Reset state
    do_reset();
    chk("rst_state", a_state, 3'd0);
    chk("rst_pop", a_pop, 32'h0);
    chk("rst_gen", a_gen, 4'd0);
    chk("rst_busy_fin", {a_busy, a_fin}, 2'b00);
    chk("rst_starts", cur_st(), 4'b0);

    // Two generations, report every generation
    max_gen  = 16'd2;
    init_pop = 32'hA5A5_0001;
    pulse_start();
    stage(4'b1000, "t1_init", 1'b1);
    stage(4'b0100, "t1_sel1", 1'b1);
    chk("t1_pop_init", a_pop, 32'hA5A5_0001);
    chk("t1_busy", a_busy, 1'b1);
    mut_pop = 32'h1111_2222;
    stage(4'b0010, "t1_mut1", 1'b1);
    chk("t1_gen1", a_gen, 4'd1);
    stage(4'b0001, "t1_rpt1", 1'b1);
    stage(4'b0100, "t1_sel2", 1'b1);
    mut_pop = 32'h3333_4444;
    stage(4'b0010, "t1_mut2", 1'b1);
    chk("t1_gen2", a_gen, 4'd2);
    stage(4'b0001, "t1_rpt2", 1'b1);
    chk("t1_done_state", a_state, 3'd6);
    chk("t1_fin_busy", {a_fin, a_busy}, 2'b10);
    chk("t1_pop_final", a_pop, 32'h3333_4444);

    // Single-step mode, unlimited run
    do_reset();
    step_mode = 1'b1;
    max_gen   = 16'd0;
    pulse_start();
    stage(4'b1000, "t3_init", 1'b0);
    stage(4'b0100, "t3_sel1", 1'b0);
    mut_pop = 32'h0F0F_0F0F;
    stage(4'b0010, "t3_mut1", 1'b0);
    stage(4'b0001, "t3_rpt1", 1'b0);
    chk("t3_hold", a_state, 3'd5);
    chk("t3_hold_busy", a_busy, 1'b0);
    chk("t3_gen1", a_gen, 4'd1);
    step_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_no_resume", a_state, 3'd5);
    step_mode = 1'b1;
    pulse_start();
    chk("t3_resume_sel", cur_st(), 4'b0100);
    stage(4'b0100, "t3_sel2", 1'b1);
    last_pop = 32'h7E57_0002;
    mut_pop  = last_pop;
    stage(4'b0010, "t3_mut2", 1'b0);
    stage(4'b0001, "t3_rpt2", 1'b0);
    chk("t3_hold2", a_state, 3'd5);
    chk("t3_gen2", a_gen, 4'd2);

    // Abort on the same edge as mut_done
    pulse_start();
    stage(4'b0100, "t4_sel", 1'b1);
    wait_start(s, w);
    chk("t4_mut_start", s, 4'b0010);
    @(negedge clk);
    mut_pop  = '1;
    mut_done = 1'b1;
    abort    = 1'b1;
    @(negedge clk);
    mut_done = 1'b0;
    abort    = 1'b0;
    chk("t4_state", a_state, 3'd0);
    chk("t4_pop", a_pop, last_pop);
    chk("t4_gen", a_gen, 4'd2);
    acc = 4'b0;
    for (int i = 0; i < 4; i++) begin
      acc = acc | cur_st();
      @(negedge clk);
    end
    chk("t4_nostart", acc, 4'b0);

    // Stray start/done pulses, then counter wrap at GEN_W=4
    do_reset();
    step_mode = 1'b0;
    max_gen   = 16'd0;
    init_pop  = 32'h0000_BEEF;
    pulse_start();
    stage(4'b1000, "t5_init", 1'b0);
    wait_start(s, w);
    chk("t5_sel", s, 4'b0100);
    pulse_start();
    chk("t5_stray_start_state", a_state, 3'd2);
    chk("t5_stray_start_pulse", cur_st(), 4'b0);
    mut_pop  = 32'hDEAD_BEEF;
    mut_done = 1'b1;
    @(negedge clk);
    mut_done = 1'b0;
    chk("t5_stray_mut_state", a_state, 3'd2);
    chk("t5_stray_mut_pop", a_pop, 32'h0000_BEEF);
    sel_done = 1'b1;
    @(negedge clk);
    sel_done = 1'b0;
    wait_start(s, w);
    chk("t5_mut", s, 4'b0010);
    sel_done = 1'b1;
    @(negedge clk);
    sel_done = 1'b0;
    chk("t5_stray_sel_state", a_state, 3'd3);
    chk("t5_stray_sel_gen", a_gen, 4'd0);
    mut_pop  = 32'h0000_0001;
    mut_done = 1'b1;
    @(negedge clk);
    mut_done = 1'b0;
    stage(4'b0001, "t5_rpt", 1'b1);
    for (int i = 0; i < 16; i++) begin
      stage(4'b0100, "t5_loop_sel", 1'b1);
      mut_pop = 32'h1000_0000 + i;
      stage(4'b0010, "t5_loop_mut", 1'b1);
      if (i == 14) chk("t5_gen_wrap0", a_gen, 4'd0);
      stage(4'b0001, "t5_loop_rpt", 1'b1);
    end
    chk("t5_gen_wrap1", a_gen, 4'd1);
    chk("t5_pop_last", a_pop, 32'h1000_000F);

    // Report decimation on instance b
    sel_b = 1'b1;
    do_reset();
    max_gen  = 16'd6;
    init_pop = 32'h0000_0B0B;
    rb0      = b_rpt_n;
    pulse_start();
    stage(4'b1000, "t2_init", 1'b0);
    for (int g = 1; g <= 6; g++) begin
      stage(4'b0100, "t2_sel", 1'b1);
      mut_pop = 32'hB000_0000 + g;
      stage(4'b0010, "t2_mut", 1'b1);
      chk("t2_gen", b_gen, g);
      if (g % 3 == 0) stage(4'b0001, "t2_rpt", 1'b1);
    end
    chk("t2_done", b_state, 3'd6);
    chk("t2_fin", b_fin, 1'b1);
    chk("t2_rpt_count", b_rpt_n - rb0, 2);
    chk("t2_pop", b_pop, 32'hB000_0006);

    chk("no_back_to_back_starts", dbl, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
